// File: rtl/prime_toggle_ctrl.sv
// ============================================================================
// prime_toggle_ctrl
// ----------------------------------------------------------------------------
// Scans the integers 2..MAX_N and tests each one for primality by trial
// division. The remainder is found by repeated subtraction, one subtract per
// clock. Every prime found is offered downstream on a valid/ready port. Each
// accepted prime also produces a one-cycle toggle_o pulse that drives the
// toggle input of a toggler instance.
//
// Parameters
//   WIDTH  width of the candidate, divisor and remainder registers
//   MAX_N  last candidate tested, 2 <= MAX_N < 2**WIDTH
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active low
//   start_i   in   starts a scan, only looked at while idle
//   abort_i   in   synchronous abort, returns to idle from any state
//   ready_i   in   downstream accepts prime_o
//   valid_o   out  prime_o holds a prime
//   prime_o   out  current prime (WIDTH bits)
//   toggle_o  out  one-cycle pulse per accepted prime
//   busy_o    out  high whenever the sequencer is not idle
//   done_o    out  one-cycle pulse when the scan completes
// ============================================================================
module prime_toggle_ctrl #(
    parameter int WIDTH = 8,
    parameter int MAX_N = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] prime_o,
    output logic             toggle_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MOD   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [WIDTH-1:0] FIRST_VALUE = WIDTH'(2);
    localparam logic [WIDTH-1:0] LAST_VALUE  = WIDTH'(MAX_N);

    logic [2:0]         r_state;
    logic [2:0]         w_nextState;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_prime;
    logic               r_valid;
    logic               r_toggle;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_dWide;
    logic [2*WIDTH-1:0] w_nWide;
    logic [2*WIDTH-1:0] w_divSquare;
    logic               w_isPrime;
    logic               w_canSubtract;
    logic               w_isLast;
    logic               w_handshake;

    // The divisor is squared at double width so the comparison against the
    // candidate can never be corrupted by overflow. Once d*d exceeds n no
    // divisor up to sqrt(n) divided it, so n is prime.
    assign w_dWide       = {{WIDTH{1'b0}}, r_d};
    assign w_nWide       = {{WIDTH{1'b0}}, r_n};
    assign w_divSquare   = w_dWide * w_dWide;
    assign w_isPrime     = (w_divSquare > w_nWide);
    assign w_canSubtract = (r_r >= r_d);
    assign w_isLast      = (r_n == LAST_VALUE);
    assign w_handshake   = (r_state == S_EMIT) && ready_i;

    // Next-state decode. Abort overrides whatever the current state wanted.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_nextState = S_LOAD;
            S_LOAD:  w_nextState = w_isPrime ? S_EMIT : S_MOD;
            S_MOD:   w_nextState = w_canSubtract ? S_MOD : S_CHECK;
            S_CHECK: w_nextState = (r_r == '0) ? S_NEXT : S_LOAD;
            S_EMIT:  if (ready_i) w_nextState = S_NEXT;
            S_NEXT:  w_nextState = w_isLast ? S_DONE : S_LOAD;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (abort_i) begin
            w_nextState = S_IDLE;
        end
    end

    // State, datapath and registered outputs. The status outputs are derived
    // from the next state so they line up exactly with the state they
    // describe. The candidate is only advanced after the last-value compare,
    // so it never wraps. An abort freezes the datapath and kills a
    // same-cycle handshake, so no toggle is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_prime  <= '0;
            r_valid  <= 1'b0;
            r_toggle <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_valid  <= (w_nextState == S_EMIT);
            r_busy   <= (w_nextState != S_IDLE);
            r_done   <= (w_nextState == S_DONE);
            r_toggle <= w_handshake && !abort_i;
            if (!abort_i) begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_n <= FIRST_VALUE;
                            r_d <= FIRST_VALUE;
                        end
                    end
                    S_LOAD: begin
                        if (w_isPrime) begin
                            r_prime <= r_n;
                        end else begin
                            r_r <= r_n;
                        end
                    end
                    S_MOD: begin
                        if (w_canSubtract) begin
                            r_r <= r_r - r_d;
                        end
                    end
                    S_CHECK: begin
                        if (r_r != '0) begin
                            r_d <= r_d + WIDTH'(1);
                        end
                    end
                    S_NEXT: begin
                        if (!w_isLast) begin
                            r_n <= r_n + WIDTH'(1);
                            r_d <= FIRST_VALUE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign valid_o  = r_valid;
    assign prime_o  = r_prime;
    assign toggle_o = r_toggle;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule
